reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer between issue and the architectural register file.
- Issue allocates one entry per instruction in program order; the execution units return results on the writeback bus.
- The head entry retires in order and drives the register file's commit port: write enable, destination, value and producer tag for status release.
- A mispredicted branch at the head raises a flush and redirect, which also clears all register status in the register file.

## Interface
- `ROB_DEPTH`, 16, number of entries (power of two)
- `ROB_ADDR_W`, 4, log2(ROB_DEPTH)

Ports:
- `clk_in` in 1 clock
- `rst_n_in` in 1 reset, asynchronous, active-low
- `rdy_in` in 1 global ready; low freezes all state
- `alloc_en_in` in 1 allocate entry this cycle
- `alloc_rd_in` in 5 destination register (0 = none)
- `alloc_is_br_in` in 1 entry is a conditional branch
- `alloc_pred_in` in 1 predicted taken
- `alloc_pc_in` in 32 instruction PC
- `alloc_tag_out` out ROB_ADDR_W tag the next allocation receives (= tail)
- `full_out` out 1 count == ROB_DEPTH
- `wb_en_in` in 1 writeback valid
- `wb_tag_in` in ROB_ADDR_W entry being completed
- `wb_value_in` in 32 result value
- `wb_taken_in` in 1 resolved branch direction
- `wb_target_in` in 32 resolved taken target
- `q1_tag_in`, `q2_tag_in` in ROB_ADDR_W operand lookup tags
- `q1_ready_out`, `q2_ready_out` out 1 tagged entry has a result
- `q1_value_out`, `q2_value_out` out 32 that result
- `commit_en_out` out 1 register write pulse
- `commit_rd_out` out 5 register written
- `commit_value_out` out 32 value written
- `commit_tag_out` out 32 retiring tag, zero-extended; drives the register file's producer-compare input
- `clear_out` out 1 flush pulse
- `redirect_pc_out` out 32 fetch restart PC, valid with clear_out

## Operation
- Entry fields: valid, done, rd, is_br, pred, pc, value, taken, target. Pointers head and tail are ROB_ADDR_W bits and wrap modulo ROB_DEPTH. count is ROB_ADDR_W+1 bits.
- Allocate:
  - Occurs when alloc_en_in && !full_out && !flush.
  - Writes entry[tail] with valid=1, done=0; tail increments.
  - Allocate while full is dropped silently. Issue must gate on full_out.
- Writeback:
  - Occurs when wb_en_in and entry[wb_tag_in].valid.
  - Sets done and stores value, taken and target. Writeback to an invalid entry is ignored.
- Retire, which sets a one-cycle commit pulse:
  - Occurs when entry[head].valid && done.
  - commit_en_out = (rd != 0); the other commit fields carry the head entry's rd, value and tag.
  - valid is cleared, head increments, count decrements.
- Mispredict:
  - Occurs when the head retires with is_br && taken != pred.
  - Same edge: clear_out=1; redirect_pc_out = taken ? target : pc+4.
  - All valid bits clear; head = tail = count = 0.
  - Allocation and writeback in that cycle are discarded.
  - The commit pulse for that entry is still emitted alongside clear_out.
- Non-mispredicted branch: retires normally with commit_en_out = (rd != 0).
- Simultaneous allocate and retire: count is unchanged. full_out is evaluated before retire, so a full buffer does not accept an allocation in the same cycle it retires.
- Query ports are combinational: ready = valid && done, value = stored value.
- `rdy_in` low: no state changes, and the commit_en_out/clear_out pulses are held low.

## Timing
- Reset (async assert, sync release): head = tail = count = 0, all valid = 0.
- Output reset values: commit_en_out, clear_out, full_out = 0. commit_rd_out, commit_value_out, commit_tag_out, redirect_pc_out = 0. alloc_tag_out = 0.
- Commit outputs, clear_out and redirect_pc_out are registered, one-cycle pulses.
- Latency:
  - Allocate at edge N; writeback at the earliest in the cycle after N, registered at edge N+1.
  - Retire decided at edge N+2; register file sees commit in cycle N+2→N+3.
  - Throughput: one retire per cycle.
- Reset asserted mid-operation discards everything immediately, including pending pulses.

## Configuration
- `ROB_WB_BYPASS_EN` defined: if wb_en_in && wb_tag_in == qN_tag_in, then qN_ready_out = 1 and qN_value_out = wb_value_in in the same cycle.
- Undefined: query ports reflect stored state only, so a result becomes visible one cycle after writeback.

## Test plan
- Reset → all outputs 0, full_out = 0, alloc_tag_out = 0.
- Allocate rd=5 (tag 0), writeback tag 0 value 0x1234 → two cycles after the allocate edge: commit_en_out = 1, rd = 5, value = 0x1234, tag = 0.
- Fill 16 entries → full_out = 1 and a 17th allocate is ignored. Then retire tag 0 and allocate → new tag 0 (wrap), count stays 16.
- Branch at pc=0x100, pred=0, wb taken=1 target=0x200 → clear_out = 1, redirect_pc_out = 0x200, next cycle count = 0, alloc_tag_out = 0. Same with pred=1/taken=0 → redirect 0x104.
- Out-of-order writeback to tags 2, 1, then 0 → commits appear in order 0, 1, 2 on consecutive cycles.
- Query tag 3 while wb tag 3 = 0x55 → with `ROB_WB_BYPASS_EN` ready = 1 and value = 0x55 in the same cycle; without it, ready = 0 in that cycle and 1 in the next. With rdy_in low for 3 cycles, no commit occurs until rdy_in returns.

Source files
------------

// File: rtl/reorder_buffer.sv
`default_nettype none
// =============================================================================
// reorder_buffer : circular in-order retirement buffer with operand query ports
// Macro ROB_WB_BYPASS_EN forwards the writeback bus to queries.  Rev 1.0
// =============================================================================
module reorder_buffer #(
   parameter int ROB_DEPTH  = 16,
   parameter int ROB_ADDR_W = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic                  alloc_en_in,
   input  logic [4:0]            alloc_rd_in,
   input  logic                  alloc_is_br_in,
   input  logic                  alloc_pred_in,
   input  logic [31:0]           alloc_pc_in,
   output logic [ROB_ADDR_W-1:0] alloc_tag_out,
   output logic                  full_out,
   input  logic                  wb_en_in,
   input  logic [ROB_ADDR_W-1:0] wb_tag_in,
   input  logic [31:0]           wb_value_in,
   input  logic                  wb_taken_in,
   input  logic [31:0]           wb_target_in,
   input  logic [ROB_ADDR_W-1:0] q1_tag_in,
   input  logic [ROB_ADDR_W-1:0] q2_tag_in,
   output logic                  q1_ready_out,
   output logic                  q2_ready_out,
   output logic [31:0]           q1_value_out,
   output logic [31:0]           q2_value_out,
   output logic                  commit_en_out,
   output logic [4:0]            commit_rd_out,
   output logic [31:0]           commit_value_out,
   output logic [31:0]           commit_tag_out,
   output logic                  clear_out,
   output logic [31:0]           redirect_pc_out
);

   logic [ROB_DEPTH-1:0]  valid_q;
   logic [ROB_DEPTH-1:0]  done_q;
   logic [ROB_DEPTH-1:0]  is_br_q;
   logic [ROB_DEPTH-1:0]  pred_q;
   logic [ROB_DEPTH-1:0]  taken_q;
   logic [4:0]            rd_q     [ROB_DEPTH];
   logic [31:0]           pc_q     [ROB_DEPTH];
   logic [31:0]           value_q  [ROB_DEPTH];
   logic [31:0]           target_q [ROB_DEPTH];

   logic [ROB_ADDR_W-1:0] head_q;
   logic [ROB_ADDR_W-1:0] tail_q;
   logic [ROB_ADDR_W:0]   count_q;
   logic [ROB_ADDR_W:0]   count_d;

   logic                  commit_en_q;
   logic [4:0]            commit_rd_q;
   logic [31:0]           commit_value_q;
   logic [31:0]           commit_tag_q;
   logic                  clear_q;
   logic [31:0]           redirect_q;

   logic                  full;
   logic                  retire;
   logic                  flush;
   logic                  alloc_fire;
   logic                  wb_fire;

   // full is taken from the pre-retire count, so a full buffer never allocates on a retire edge
   assign full       = (count_q == (ROB_ADDR_W+1)'(ROB_DEPTH));
   assign retire     = rdy_in && valid_q[head_q] && done_q[head_q];
   assign flush      = retire && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
   assign alloc_fire = rdy_in && alloc_en_in && !full && !flush;
   assign wb_fire    = rdy_in && wb_en_in && valid_q[wb_tag_in] && !flush;

   always_comb begin
      count_d = count_q;
      if (alloc_fire && !retire) begin
         count_d = count_q + (ROB_ADDR_W+1)'(1);
      end else if (!alloc_fire && retire) begin
         count_d = count_q - (ROB_ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_en_q    <= 1'b0;
         commit_rd_q    <= '0;
         commit_value_q <= '0;
         commit_tag_q   <= '0;
         clear_q        <= 1'b0;
         redirect_q     <= '0;
      end else if (rdy_in) begin
         commit_en_q <= retire && (rd_q[head_q] != 5'd0);
         clear_q     <= flush;
         if (retire) begin
            commit_rd_q    <= rd_q[head_q];
            commit_value_q <= value_q[head_q];
            commit_tag_q   <= 32'(head_q);
         end
         if (flush) begin
            redirect_q <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
         end else begin
            if (retire) begin
               valid_q[head_q] <= 1'b0;
               head_q          <= head_q + ROB_ADDR_W'(1);
            end
            if (alloc_fire) begin
               valid_q[tail_q] <= 1'b1;
               tail_q          <= tail_q + ROB_ADDR_W'(1);
            end
            count_q <= count_d;
         end
      end else begin
         commit_en_q <= 1'b0;
         clear_q     <= 1'b0;
      end
   end

   // Payload needs no reset: valid_q alone qualifies every field
   always_ff @(posedge clk_in) begin
      if (alloc_fire) begin
         done_q[tail_q]  <= 1'b0;
         rd_q[tail_q]    <= alloc_rd_in;
         is_br_q[tail_q] <= alloc_is_br_in;
         pred_q[tail_q]  <= alloc_pred_in;
         pc_q[tail_q]    <= alloc_pc_in;
      end
      if (wb_fire) begin
         done_q[wb_tag_in]   <= 1'b1;
         value_q[wb_tag_in]  <= wb_value_in;
         taken_q[wb_tag_in]  <= wb_taken_in;
         target_q[wb_tag_in] <= wb_target_in;
      end
   end

   always_comb begin
      q1_ready_out = valid_q[q1_tag_in] && done_q[q1_tag_in];
      q1_value_out = value_q[q1_tag_in];
      q2_ready_out = valid_q[q2_tag_in] && done_q[q2_tag_in];
      q2_value_out = value_q[q2_tag_in];
`ifdef ROB_WB_BYPASS_EN
      if (wb_en_in && (wb_tag_in == q1_tag_in)) begin
         q1_ready_out = 1'b1;
         q1_value_out = wb_value_in;
      end
      if (wb_en_in && (wb_tag_in == q2_tag_in)) begin
         q2_ready_out = 1'b1;
         q2_value_out = wb_value_in;
      end
`endif
   end

   assign alloc_tag_out    = tail_q;
   assign full_out         = full;
   assign commit_en_out    = commit_en_q;
   assign commit_rd_out    = commit_rd_q;
   assign commit_value_out = commit_value_q;
   assign commit_tag_out   = commit_tag_q;
   assign clear_out        = clear_q;
   assign redirect_pc_out  = redirect_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// =============================================================================
// tb_reorder_buffer : directed scoreboard bench for reorder_buffer
// Honours ROB_WB_BYPASS_EN for the query-port expectations.  Rev 1.0
// =============================================================================
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdy;
   logic        alloc_en;
   logic [4:0]  alloc_rd;
   logic        alloc_is_br;
   logic        alloc_pred;
   logic [31:0] alloc_pc;
   logic [3:0]  alloc_tag;
   logic        full;
   logic        wb_en;
   logic [3:0]  wb_tag;
   logic [31:0] wb_value;
   logic        wb_taken;
   logic [31:0] wb_target;
   logic [3:0]  q1_tag, q2_tag;
   logic        q1_ready, q2_ready;
   logic [31:0] q1_value, q2_value;
   logic        commit_en;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [31:0] commit_tag;
   logic        clear;
   logic [31:0] redirect_pc;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] val;
      logic [31:0] tag;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] exp_tail;
   int         checks   = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   reorder_buffer #(.ROB_DEPTH(16), .ROB_ADDR_W(4)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
      .alloc_en_in(alloc_en), .alloc_rd_in(alloc_rd), .alloc_is_br_in(alloc_is_br),
      .alloc_pred_in(alloc_pred), .alloc_pc_in(alloc_pc),
      .alloc_tag_out(alloc_tag), .full_out(full),
      .wb_en_in(wb_en), .wb_tag_in(wb_tag), .wb_value_in(wb_value),
      .wb_taken_in(wb_taken), .wb_target_in(wb_target),
      .q1_tag_in(q1_tag), .q2_tag_in(q2_tag),
      .q1_ready_out(q1_ready), .q2_ready_out(q2_ready),
      .q1_value_out(q1_value), .q2_value_out(q2_value),
      .commit_en_out(commit_en), .commit_rd_out(commit_rd),
      .commit_value_out(commit_value), .commit_tag_out(commit_tag),
      .clear_out(clear), .redirect_pc_out(redirect_pc)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; rdy = 1'b1; alloc_en = 1'b0; alloc_rd = '0; alloc_is_br = 1'b0;
      alloc_pred = 1'b0; alloc_pc = '0; wb_en = 1'b0; wb_tag = '0; wb_value = '0;
      wb_taken = 1'b0; wb_target = '0; q1_tag = '0; q2_tag = '0;
      sb.delete();
      exp_tail = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic do_alloc(input logic [4:0] rd, input logic br, input logic pred,
                           input logic [31:0] pc, input logic [31:0] expv, input bit push);
      alloc_en = 1'b1; alloc_rd = rd; alloc_is_br = br; alloc_pred = pred; alloc_pc = pc;
      if (push) begin
         sb.push_back('{rd: rd, val: expv, tag: 32'(exp_tail)});
         exp_tail = exp_tail + 4'd1;
      end
      tick();
      alloc_en = 1'b0;
   endtask

   task automatic do_wb(input logic [3:0] tag, input logic [31:0] v,
                        input logic tk, input logic [31:0] tgt);
      wb_en = 1'b1; wb_tag = tag; wb_value = v; wb_taken = tk; wb_target = tgt;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   // Commit monitor: every commit pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && commit_en) begin
         if (sb.size() == 0) begin
            chk("unexpected_commit", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("commit_rd", 32'(commit_rd), 32'(e.rd));
            chk("commit_value", commit_value, e.val);
            chk("commit_tag", commit_tag, e.tag);
         end
      end
   end

   initial begin
      do_reset();
      chk("rst_commit_en", 32'(commit_en), 0);
      chk("rst_clear", 32'(clear), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_alloc_tag", 32'(alloc_tag), 0);
      chk("rst_commit_rd", 32'(commit_rd), 0);
      chk("rst_commit_value", commit_value, 0);
      chk("rst_commit_tag", commit_tag, 0);
      chk("rst_redirect", redirect_pc, 0);

      // Single instruction: commit two edges after the allocate edge
      do_alloc(5'd5, 1'b0, 1'b0, 32'h0, 32'h1234, 1'b1);
      do_wb(4'd0, 32'h1234, 1'b0, 32'h0);
      chk("basic_commit_en_early", 32'(commit_en), 0);
      tick();
      chk("basic_commit_en", 32'(commit_en), 1);
      chk("basic_commit_value", commit_value, 32'h1234);
      tick();
      chk("basic_pulse_end", 32'(commit_en), 0);

      // Fill, overflow, retire-while-full, wrap
      do_reset();
      for (int i = 0; i < 16; i++) begin
         chk("fill_not_full", 32'(full), 0);
         do_alloc(5'(i + 1), 1'b0, 1'b0, 32'(i * 4), 32'h1000 + 32'(i), 1'b1);
      end
      chk("fill_full", 32'(full), 1);
      chk("fill_tag_wrap", 32'(alloc_tag), 0);
      do_alloc(5'd30, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("overflow_tag", 32'(alloc_tag), 0);
      chk("overflow_full", 32'(full), 1);
      do_wb(4'd0, 32'h1000, 1'b0, 32'h0);
      do_alloc(5'd7, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("retire_edge_alloc_blocked_tag", 32'(alloc_tag), 0);
      chk("retire_edge_not_full", 32'(full), 0);
      do_alloc(5'd9, 1'b0, 1'b0, 32'h0, 32'h2000, 1'b1);
      chk("wrap_alloc_full", 32'(full), 1);
      chk("wrap_alloc_tag", 32'(alloc_tag), 1);
      for (int i = 1; i < 16; i++) do_wb(4'(i), 32'h1000 + 32'(i), 1'b0, 32'h0);
      do_wb(4'd0, 32'h2000, 1'b0, 32'h0);
      drain("fill_drain");

      // Mispredict pred=0 taken=1; alloc and writeback on the flush edge are discarded
      do_reset();
      do_alloc(5'd0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
      do_alloc(5'd3, 1'b0, 1'b0, 32'h104, 32'h0, 1'b0);
      do_wb(4'd0, 32'h0, 1'b1, 32'h200);
      alloc_en = 1'b1; alloc_rd = 5'd11; alloc_is_br = 1'b0;
      wb_en = 1'b1; wb_tag = 4'd1; wb_value = 32'hDEAD; q1_tag = 4'd1;
      tick();
      alloc_en = 1'b0; wb_en = 1'b0;
      chk("mp1_clear", 32'(clear), 1);
      chk("mp1_redirect", redirect_pc, 32'h200);
      chk("mp1_commit_en", 32'(commit_en), 0);
      chk("mp1_alloc_tag", 32'(alloc_tag), 0);
      chk("mp1_full", 32'(full), 0);
      chk("mp1_q1_ready", 32'(q1_ready), 0);
      tick();
      chk("mp1_clear_pulse_end", 32'(clear), 0);
      exp_tail = 4'd0;

      // Mispredict pred=1 taken=0 with a destination: commit accompanies the flush
      do_alloc(5'd4, 1'b1, 1'b1, 32'h100, 32'h77, 1'b1);
      do_wb(4'd0, 32'h77, 1'b0, 32'h300);
      tick();
      chk("mp2_clear", 32'(clear), 1);
      chk("mp2_redirect", redirect_pc, 32'h104);
      chk("mp2_commit_en", 32'(commit_en), 1);
      exp_tail = 4'd0;
      tick();

      // Correctly predicted branch retires without flush
      do_alloc(5'd6, 1'b1, 1'b1, 32'h40, 32'h66, 1'b1);
      do_wb(4'd0, 32'h66, 1'b1, 32'h80);
      tick();
      chk("okbr_clear", 32'(clear), 0);
      chk("okbr_commit_en", 32'(commit_en), 1);
      tick();

      // Reset during a commit pulse kills it immediately
      do_alloc(5'd8, 1'b0, 1'b0, 32'h0, 32'h88, 1'b0);
      do_wb(4'd1, 32'h88, 1'b0, 32'h0);
      tick();
      chk("midrst_pulse_before", 32'(commit_en), 1);
      chk("midrst_tag_before", commit_tag, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_commit_en", 32'(commit_en), 0);
      chk("midrst_commit_tag", commit_tag, 0);
      chk("midrst_alloc_tag", 32'(alloc_tag), 0);
      do_reset();

      // Out-of-order writeback retires in program order on consecutive cycles
      do_alloc(5'd1, 1'b0, 1'b0, 32'h0, 32'hA0, 1'b1);
      do_alloc(5'd2, 1'b0, 1'b0, 32'h4, 32'hA1, 1'b1);
      do_alloc(5'd3, 1'b0, 1'b0, 32'h8, 32'hA2, 1'b1);
      do_wb(4'd2, 32'hA2, 1'b0, 32'h0);
      do_wb(4'd1, 32'hA1, 1'b0, 32'h0);
      do_wb(4'd0, 32'hA0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ooo_commit_en", 32'(commit_en), 1);
         chk("ooo_commit_tag", commit_tag, 32'(i));
      end
      drain("ooo_drain");

      // Query ports with and without writeback bypass
      do_reset();
      do_alloc(5'd1, 1'b0, 1'b0, 32'h0, 32'h50, 1'b1);
      do_alloc(5'd2, 1'b0, 1'b0, 32'h4, 32'h51, 1'b1);
      do_alloc(5'd3, 1'b0, 1'b0, 32'h8, 32'h52, 1'b1);
      do_alloc(5'd4, 1'b0, 1'b0, 32'hC, 32'h55, 1'b1);
      wb_en = 1'b1; wb_tag = 4'd3; wb_value = 32'h55; wb_taken = 1'b0;
      q1_tag = 4'd3; q2_tag = 4'd0;
      #1;
`ifdef ROB_WB_BYPASS_EN
      chk("q1_bypass_ready", 32'(q1_ready), 1);
      chk("q1_bypass_value", q1_value, 32'h55);
`else
      chk("q1_nobypass_ready", 32'(q1_ready), 0);
`endif
      chk("q2_not_ready", 32'(q2_ready), 0);
      tick();
      wb_en = 1'b0;
      chk("q1_ready_next", 32'(q1_ready), 1);
      chk("q1_value_next", q1_value, 32'h55);

      // rdy low freezes retire and allocation
      do_wb(4'd0, 32'h50, 1'b0, 32'h0);
      rdy = 1'b0;
      alloc_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_commit_en", 32'(commit_en), 0);
         chk("stall_alloc_tag", 32'(alloc_tag), 4);
      end
      alloc_en = 1'b0;
      rdy = 1'b1;
      tick();
      chk("stall_release_commit", 32'(commit_en), 1);
      chk("stall_release_tag", commit_tag, 0);
      do_wb(4'd1, 32'h51, 1'b0, 32'h0);
      do_wb(4'd2, 32'h52, 1'b0, 32'h0);
      drain("query_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
